sdft_core: RTL and testbench
============================

# sdft_core

Sliding discrete Fourier transform engine. Holds a circular window of the last `freq_bins` signed input samples and, for each new sample, updates all `freq_bins` complex frequency bins in place with the recurrence X_k ← (X_k + x_new − x_old)·e^{j2πk/N}, one bin per clock. It sits between a sample source (start/ready handshake) and a spectrum consumer (random-access bin read port).

## Interface
- `data_width`, 8: input sample width, signed two's complement.
- `freq_bins`, 128: window length N and number of bins; power of two, ≥4.
- `freq_data_width`, 16: signed width of each bin's real and imag word.
- `twiddle_width`, 16: signed twiddle width; scale 2^(twiddle_width−2) represents 1.0.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `sample` in `data_width`: new signed sample, captured on accept.
- `start` in 1: level request; accepted on any rising edge where the block is idle.
- `ready` out 1: high when idle and able to accept.
- `rd_addr` in log2(N): bin index for readout.
- `rd_real` out `freq_data_width`: registered real part of bin `rd_addr`.
- `rd_imag` out `freq_data_width`: registered imag part of bin `rd_addr`.

## Operation
- Storage: `samples[0..N-1]` (data_width), `frequency_bins_real[0..N-1]`, `frequency_bins_imag[0..N-1]`, write pointer `ptr`. Internal names fixed so benches can probe them.
- Twiddle ROM: cos_k = round(cos(2πk/N)·2^(tw−2)), sin_k = round(sin(2πk/N)·2^(tw−2)), built at elaboration.
- States: IDLE (ready=1), COMPUTE (ready=0, bin counter k).
- IDLE & start: x_old ← samples[ptr]; samples[ptr] ← sample; delta ← sample − x_old (data_width+1 bits); ptr ← ptr+1 mod N; k ← 0; go COMPUTE.
- COMPUTE, per cycle for bin k: sr = X_re[k] + delta, si = X_im[k] (sign-extended); X_re[k] ← (sr·cos_k − si·sin_k) >>> (tw−2); X_im[k] ← (sr·sin_k + si·cos_k) >>> (tw−2). Shift is arithmetic (truncate toward −∞). k = N−1 → IDLE.
- Bin 0 uses exact twiddle 1+j0, so X_re[0] is the exact integer window sum, X_im[0] stays 0.
- Window starts zero-filled, so the first N updates subtract 0.
- `start` while in COMPUTE is ignored (no queuing); `sample` only sampled at accept.
- Read port: rd_real/rd_imag ← bin[rd_addr] each edge, in any state; reads during COMPUTE may mix updated and pending bins.
- Reset (and power-up initial values, identical): all samples and bins 0, ptr 0, IDLE, ready 1, rd_real/rd_imag 0. Reset mid-COMPUTE aborts the frame and clears everything.

## Timing
- Accept at edge t → ready 0 from t+1; bins 0..N−1 updated at edges t+1..t+N; ready 1 after edge t+N. Busy = exactly N cycles.
- `start` still high when ready returns: new sample accepted on the next edge (back-to-back throughput N+1 cycles/sample).
- Read latency: 1 cycle from `rd_addr` to `rd_real`/`rd_imag`.

## Configuration
- `SDFT_SATURATE_EN`: defined → each bin result clamps to [−2^(fdw−1), 2^(fdw−1)−1] before write-back. Undefined → result truncated to `freq_data_width` bits (two's-complement wrap). Default builds leave it undefined; the test plan values never overflow either way.

## Test plan
- Reset: assert reset 2 cycles → ready=1, all bins and samples 0, rd_real=rd_imag=0 for every address.
- Handshake: hold start with sample=−100 until ready falls, then drop → ready low exactly 128 cycles, samples[0]=−100, ptr=1; start during busy leaves ptr unchanged.
- Constant: 64 samples of −100 → bin0 real=−6400, imag=0.
- Square wave: 64×(−100), 64×(+100) → bin0 real=0; |bin1| within 2% of 200/sin(π/128)≈8150; bins 2,4 |X|<1% of that.
- Second period (repeat pattern; window wraps ptr 127→0) → bin0 real=0; bin1 magnitude matches first period within 2%; odd bins dominate even bins.
- Saturation (`SDFT_SATURATE_EN`, freq_data_width=12): 128 samples of +127 → bin0 real=2047, not wrapped negative.

Source files
------------

// File: rtl/sdft_core.sv
// Sliding DFT engine: circular sample window plus in-place bin update, one bin per clock.
// Optional build macro SDFT_SATURATE_EN clamps each bin result instead of wrapping it.
module sdft_core #(
    parameter int data_width      = 8,
    parameter int freq_bins       = 128,
    parameter int freq_data_width = 16,
    parameter int twiddle_width   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [data_width-1:0]       sample,
    input  logic                               start,
    output logic                               ready,
    input  logic [$clog2(freq_bins)-1:0]       rd_addr,
    output logic signed [freq_data_width-1:0]  rd_real,
    output logic signed [freq_data_width-1:0]  rd_imag
);

    // state   | meaning
    // IDLE    | ready=1, waiting for start
    // COMPUTE | ready=0, updating bin k_q (0..N-1)
    typedef enum logic {IDLE, COMPUTE} state_t;

    localparam int AW  = $clog2(freq_bins);
    localparam int DW1 = data_width + 1;
    localparam int SW  = ((freq_data_width > DW1) ? freq_data_width : DW1) + 1;
    localparam int PW  = SW + twiddle_width;
    localparam int ACW = PW + 1;
    localparam int SH  = twiddle_width - 2;

    state_t                              state_q;
    logic                                ready_q;
    logic [AW-1:0]                       k_q;
    logic signed [DW1-1:0]               delta_q;
    logic [AW-1:0]                       ptr;
    logic signed [data_width-1:0]        samples             [freq_bins];
    logic signed [freq_data_width-1:0]   frequency_bins_real [freq_bins];
    logic signed [freq_data_width-1:0]   frequency_bins_imag [freq_bins];
    logic signed [freq_data_width-1:0]   rd_real_q;
    logic signed [freq_data_width-1:0]   rd_imag_q;

    logic signed [twiddle_width-1:0]     cos_rom [freq_bins];
    logic signed [twiddle_width-1:0]     sin_rom [freq_bins];

    logic signed [SW-1:0]                sr, si;
    logic signed [twiddle_width-1:0]     ck, sk;
    logic signed [PW-1:0]                p_rc, p_is, p_rs, p_ic;
    logic signed [ACW-1:0]               acc_re, acc_im;
    logic signed [freq_data_width-1:0]   upd_re_d, upd_im_d;

    // Rounded twiddle factors; scale 2^(twiddle_width-2) is 1.0, so bin 0 is exactly 1+j0.
    function automatic logic signed [twiddle_width-1:0] tw_val(input int k, input bit want_sin);
        real ang;
        real v;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(freq_bins);
        v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(2 ** SH);
        if (v >= 0.0)
            return twiddle_width'($rtoi(v + 0.5));
        else
            return twiddle_width'(-$rtoi(-v + 0.5));
    endfunction

    for (genvar g = 0; g < freq_bins; g++) begin : g_rom
        assign cos_rom[g] = tw_val(g, 1'b0);
        assign sin_rom[g] = tw_val(g, 1'b1);
    end

`ifdef SDFT_SATURATE_EN
    localparam logic signed [ACW-1:0] MAXV = ACW'((2 ** (freq_data_width - 1)) - 1);
    localparam logic signed [ACW-1:0] MINV = -MAXV - ACW'(1);

    function automatic logic signed [freq_data_width-1:0] fit(input logic signed [ACW-1:0] v);
        if (v > MAXV)
            return freq_data_width'(MAXV);
        else if (v < MINV)
            return freq_data_width'(MINV);
        else
            return freq_data_width'(v);
    endfunction
`else
    function automatic logic signed [freq_data_width-1:0] fit(input logic signed [ACW-1:0] v);
        return freq_data_width'(v);
    endfunction
`endif

    always_comb begin
        sr       = SW'(frequency_bins_real[k_q]) + SW'(delta_q);
        si       = SW'(frequency_bins_imag[k_q]);
        ck       = cos_rom[k_q];
        sk       = sin_rom[k_q];
        p_rc     = PW'(sr) * PW'(ck);
        p_is     = PW'(si) * PW'(sk);
        p_rs     = PW'(sr) * PW'(sk);
        p_ic     = PW'(si) * PW'(ck);
        acc_re   = ACW'(p_rc) - ACW'(p_is);
        acc_im   = ACW'(p_rs) + ACW'(p_ic);
        // Arithmetic shift floors toward minus infinity before the fit to bin width.
        upd_re_d = fit(acc_re >>> SH);
        upd_im_d = fit(acc_im >>> SH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            k_q       <= '0;
            delta_q   <= '0;
            ptr       <= '0;
            rd_real_q <= '0;
            rd_imag_q <= '0;
            for (int i = 0; i < freq_bins; i++) begin
                samples[i]             <= '0;
                frequency_bins_real[i] <= '0;
                frequency_bins_imag[i] <= '0;
            end
        end else begin
            rd_real_q <= frequency_bins_real[rd_addr];
            rd_imag_q <= frequency_bins_imag[rd_addr];
            case (state_q)
                IDLE: begin
                    if (start) begin
                        samples[ptr] <= sample;
                        delta_q      <= DW1'(sample) - DW1'(samples[ptr]);
                        ptr          <= ptr + AW'(1);
                        k_q          <= '0;
                        state_q      <= COMPUTE;
                        ready_q      <= 1'b0;
                    end
                end
                COMPUTE: begin
                    frequency_bins_real[k_q] <= upd_re_d;
                    frequency_bins_imag[k_q] <= upd_im_d;
                    if (k_q == AW'(freq_bins - 1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign rd_real = rd_real_q;
    assign rd_imag = rd_imag_q;

endmodule

// File: tb/tb_sdft_core.sv
// Directed bench for sdft_core: reset, handshake timing, constant and square-wave spectra.
module tb_sdft_core;
    localparam int DW = 8;
    localparam int NB = 128;
    localparam int TW = 16;
`ifdef SDFT_SATURATE_EN
    localparam int FDW = 12;
`else
    localparam int FDW = 16;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   ready;
    logic signed [DW-1:0]   sample;
    logic [6:0]             rd_addr;
    logic signed [FDW-1:0]  rd_real;
    logic signed [FDW-1:0]  rd_imag;

    int n_chk  = 0;
    int n_pass = 0;

    sdft_core #(
        .data_width(DW), .freq_bins(NB), .freq_data_width(FDW), .twiddle_width(TW)
    ) dut (
        .clk(clk), .reset(reset), .sample(sample), .start(start), .ready(ready),
        .rd_addr(rd_addr), .rd_real(rd_real), .rd_imag(rd_imag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input real v, input real lo, input real hi);
        n_chk++;
        assert (v >= lo && v <= hi) n_pass++;
        else $error("FAIL %s: observed %0.2f expected within [%0.2f, %0.2f]", tag, v, lo, hi);
    endtask

    task automatic read_bin(input int a, output int re, output int im);
        rd_addr = 7'(a);
        tick();
        re = int'(rd_real);
        im = int'(rd_imag);
    endtask

    function automatic real mag(input int re, input int im);
        return $sqrt(real'(re) * real'(re) + real'(im) * real'(im));
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, (ready === 1'b1) ? 1 : 0, 1);
    endtask

    task automatic push(input int v);
        wait_ready("push_ready");
        sample = DW'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic all_zero(output int nz);
        nz = 0;
        for (int i = 0; i < NB; i++) begin
            if (dut.samples[i] != 0) nz++;
            if (dut.frequency_bins_real[i] != 0) nz++;
            if (dut.frequency_bins_imag[i] != 0) nz++;
        end
    endtask

    initial begin
        int   n, busy, cyc, nz, prev, acc;
        int   re0, im0, re1, im1, re2, im2, re3, im3, re4, im4;
        real  ref1, m1_first;

        reset   = 1'b1;
        start   = 1'b0;
        sample  = '0;
        rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", int'(ready), 1);
        chk("rst_rd_real", int'(rd_real), 0);
        chk("rst_rd_imag", int'(rd_imag), 0);
        chk("rst_ptr", int'(dut.ptr), 0);
        all_zero(nz);
        chk("rst_storage_zero", nz, 0);
        nz = 0;
        for (int a = 0; a < NB; a++) begin
            read_bin(a, re0, im0);
            if (re0 != 0 || im0 != 0) nz++;
        end
        chk("rst_readport_zero", nz, 0);

`ifdef SDFT_SATURATE_EN
        for (int i = 0; i < NB; i++) push(127);
        wait_ready("sat_done");
        read_bin(0, re0, im0);
        chk("sat_bin0_real", re0, 2047);
        chk("sat_bin0_imag", im0, 0);
`else
        // Hold start until the block takes it, poke start mid-frame, measure busy time.
        sample = -8'sd100;
        start  = 1'b1;
        n = 0;
        while (ready === 1'b1 && n < 5) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("hs_accept_edges", n, 1);
        busy = 0;
        while (ready !== 1'b1 && busy < 300) begin
            tick();
            busy++;
            if (busy == 40) begin
                sample = 8'sd55;
                start  = 1'b1;
            end
            if (busy == 60) start = 1'b0;
        end
        chk("hs_busy_cycles", busy, 128);
        chk("hs_ptr", int'(dut.ptr), 1);
        chk("hs_sample0", int'(dut.samples[0]), -100);
        chk("hs_sample1", int'(dut.samples[1]), 0);

        for (int i = 0; i < 63; i++) push(-100);
        wait_ready("const_done");
        read_bin(0, re0, im0);
        chk("const_bin0_real", re0, -6400);
        chk("const_bin0_imag", im0, 0);

        // Back-to-back: start held high, 64 accepts spaced N+1 cycles apart.
        wait_ready("stream_ready");
        sample = 8'sd100;
        start  = 1'b1;
        acc = 0;
        cyc = 0;
        prev = 1;
        while (acc < 64 && cyc < 64 * 140) begin
            tick();
            cyc++;
            if (ready === 1'b0 && prev == 1) acc++;
            prev = (ready === 1'b1) ? 1 : 0;
        end
        start = 1'b0;
        chk("stream_cycles", cyc, 63 * 129 + 1);
        wait_ready("square_done");
        chk("square_ptr_wrap", int'(dut.ptr), 0);

        ref1 = 200.0 / $sin(3.14159265358979323846 / 128.0);
        read_bin(0, re0, im0);
        read_bin(1, re1, im1);
        read_bin(2, re2, im2);
        read_bin(4, re4, im4);
        chk("sq_bin0_real", re0, 0);
        chk("sq_bin0_imag", im0, 0);
        m1_first = mag(re1, im1);
        chk_rng("sq_bin1_mag", m1_first, 0.98 * ref1, 1.02 * ref1);
        chk_rng("sq_bin2_mag", mag(re2, im2), 0.0, 0.01 * ref1);
        chk_rng("sq_bin4_mag", mag(re4, im4), 0.0, 0.01 * ref1);

        for (int i = 0; i < 64; i++) push(-100);
        for (int i = 0; i < 64; i++) push(100);
        wait_ready("second_done");
        chk("p2_ptr_wrap", int'(dut.ptr), 0);
        read_bin(0, re0, im0);
        read_bin(1, re1, im1);
        read_bin(2, re2, im2);
        read_bin(3, re3, im3);
        read_bin(4, re4, im4);
        chk("p2_bin0_real", re0, 0);
        chk("p2_bin0_imag", im0, 0);
        chk_rng("p2_bin1_mag", mag(re1, im1), 0.98 * m1_first, 1.02 * m1_first);
        chk("p2_bin1_gt_bin2", (mag(re1, im1) > mag(re2, im2)) ? 1 : 0, 1);
        chk("p2_bin3_gt_bin4", (mag(re3, im3) > mag(re4, im4)) ? 1 : 0, 1);

        // Reset in the middle of a frame clears everything.
        push(50);
        tick();
        tick();
        chk("mid_busy", int'(ready), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", int'(ready), 1);
        chk("mid_rst_ptr", int'(dut.ptr), 0);
        all_zero(nz);
        chk("mid_rst_storage_zero", nz, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
